// File: rtl/fetch_queue.sv
// Instruction fetch queue: accepts up to two fetched instructions per cycle into a
// circular per-instruction buffer and presents the two oldest, in order, to pre-decode.
module fetch_queue #(
  parameter int DEPTH           = 8,
  parameter int PTR_W           = 3,
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int BP_GHR_BITS     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 enq_valid,
  input  logic [INST_WIDTH-1:0]      enq_inst_0,
  input  logic [INST_WIDTH-1:0]      enq_inst_1,
  input  logic [INST_ADDR_WIDTH-1:0] enq_pc_0,
  input  logic [INST_ADDR_WIDTH-1:0] enq_pc_1,
  input  logic                       enq_pred_taken_0,
  input  logic                       enq_pred_taken_1,
  input  logic [INST_ADDR_WIDTH-1:0] enq_pred_target_0,
  input  logic [INST_ADDR_WIDTH-1:0] enq_pred_target_1,
  input  logic [BP_GHR_BITS-1:0]     enq_pred_hist_0,
  input  logic [BP_GHR_BITS-1:0]     enq_pred_hist_1,
  output logic                       enq_ready,
  input  logic                       stall,
  output logic [1:0]                 out_inst_valid,
  output logic [INST_WIDTH-1:0]      out_inst_0,
  output logic [INST_WIDTH-1:0]      out_inst_1,
  output logic [INST_ADDR_WIDTH-1:0] out_pc_0,
  output logic [INST_ADDR_WIDTH-1:0] out_pc_1,
  output logic                       out_pred_taken_0,
  output logic                       out_pred_taken_1,
  output logic [INST_ADDR_WIDTH-1:0] out_pred_target_0,
  output logic [INST_ADDR_WIDTH-1:0] out_pred_target_1,
  output logic [BP_GHR_BITS-1:0]     out_pred_hist_0,
  output logic [BP_GHR_BITS-1:0]     out_pred_hist_1,
  output logic [PTR_W:0]             count
);

  typedef struct packed {
    logic [INST_WIDTH-1:0]      inst;
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic                       taken;
    logic [INST_ADDR_WIDTH-1:0] target;
    logic [BP_GHR_BITS-1:0]     hist;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in0, in1, out0, out1;
  logic [PTR_W-1:0] head, tail;
  logic             enq_fire, deq_fire;
  logic [1:0]       n_enq, n_deq;

  assign in0 = '{inst: enq_inst_0, pc: enq_pc_0, taken: enq_pred_taken_0,
                 target: enq_pred_target_0, hist: enq_pred_hist_0};
  assign in1 = '{inst: enq_inst_1, pc: enq_pc_1, taken: enq_pred_taken_1,
                 target: enq_pred_target_1, hist: enq_pred_hist_1};

  // Free space counts only what is already registered; same-cycle dequeues are not credited.
  assign enq_ready = count <= (PTR_W+1)'(DEPTH - 2);
  assign enq_fire  = enq_ready && !flush && (enq_valid != 2'b00);
  assign n_enq     = enq_fire ? ({1'b0, enq_valid[0]} + {1'b0, enq_valid[1]}) : 2'd0;

  assign out_inst_valid = flush ? 2'b00 : {count > (PTR_W+1)'(1), count != '0};
  assign deq_fire       = !stall && !flush;
  assign n_deq          = deq_fire ? ({1'b0, out_inst_valid[0]} + {1'b0, out_inst_valid[1]}) : 2'd0;

  // NOTE: entry storage has no reset; head/tail/count define which entries are live,
  // so clearing the array would only add reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      // A lone slot-1 instruction is compacted down to the tail entry.
      mem[tail] <= enq_valid[0] ? in0 : in1;
      if (&enq_valid) mem[tail + PTR_W'(1)] <= in1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
    end
  end

  // NOTE: defaults first in always_comb, so no path leaves a signal unassigned (no latch).
  always_comb begin
    out0 = '0;
    out1 = '0;
    if (out_inst_valid[0]) out0 = mem[head];
    if (out_inst_valid[1]) out1 = mem[head + PTR_W'(1)];
  end

  assign out_inst_0        = out0.inst;
  assign out_inst_1        = out1.inst;
  assign out_pc_0          = out0.pc;
  assign out_pc_1          = out1.pc;
  assign out_pred_taken_0  = out0.taken;
  assign out_pred_taken_1  = out1.taken;
  assign out_pred_target_0 = out0.target;
  assign out_pred_target_1 = out1.target;
  assign out_pred_hist_0   = out0.hist;
  assign out_pred_hist_1   = out1.hist;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed hand sequences plus a vector table
// covering fill, backpressure, pointer wrap and odd-count drain.
module tb_fetch_queue;

  localparam int PTR_W = 3;

  logic        clk = 1'b0;
  logic        rst, flush, stall;
  logic [1:0]  enq_valid;
  logic [31:0] enq_inst_0, enq_inst_1, enq_pc_0, enq_pc_1;
  logic        enq_pred_taken_0, enq_pred_taken_1;
  logic [31:0] enq_pred_target_0, enq_pred_target_1;
  logic [7:0]  enq_pred_hist_0, enq_pred_hist_1;
  logic        enq_ready;
  logic [1:0]  out_inst_valid;
  logic [31:0] out_inst_0, out_inst_1, out_pc_0, out_pc_1;
  logic        out_pred_taken_0, out_pred_taken_1;
  logic [31:0] out_pred_target_0, out_pred_target_1;
  logic [7:0]  out_pred_hist_0, out_pred_hist_1;
  logic [PTR_W:0] count;

  fetch_queue #(.DEPTH(8), .PTR_W(PTR_W), .INST_WIDTH(32), .INST_ADDR_WIDTH(32),
                .BP_GHR_BITS(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid),
    .enq_inst_0(enq_inst_0), .enq_inst_1(enq_inst_1),
    .enq_pc_0(enq_pc_0), .enq_pc_1(enq_pc_1),
    .enq_pred_taken_0(enq_pred_taken_0), .enq_pred_taken_1(enq_pred_taken_1),
    .enq_pred_target_0(enq_pred_target_0), .enq_pred_target_1(enq_pred_target_1),
    .enq_pred_hist_0(enq_pred_hist_0), .enq_pred_hist_1(enq_pred_hist_1),
    .enq_ready(enq_ready), .stall(stall), .out_inst_valid(out_inst_valid),
    .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
    .out_pc_0(out_pc_0), .out_pc_1(out_pc_1),
    .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
    .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
    .out_pred_hist_0(out_pred_hist_0), .out_pred_hist_1(out_pred_hist_1),
    .count(count)
  );

  always #5 clk = ~clk;

  // Payload and prediction fields are derived from the PC so the expected data follows the PC.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[19:0], 12'h093};
  endfunction
  function automatic logic [31:0] target_of(input logic [31:0] pc);
    return pc + 32'h100;
  endfunction
  function automatic logic [7:0] hist_of(input logic [31:0] pc);
    return pc[9:2] ^ 8'hA5;
  endfunction

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic f, input logic s, input logic [1:0] ev,
                       input logic [31:0] p0, input logic [31:0] p1);
    rst = r; flush = f; stall = s; enq_valid = ev;
    enq_pc_0 = p0; enq_pc_1 = p1;
    enq_inst_0 = inst_of(p0); enq_inst_1 = inst_of(p1);
    enq_pred_taken_0 = p0[2]; enq_pred_taken_1 = p1[2];
    enq_pred_target_0 = target_of(p0); enq_pred_target_1 = target_of(p1);
    enq_pred_hist_0 = hist_of(p0); enq_pred_hist_1 = hist_of(p1);
  endtask

  // Compare both output slots against PC-derived payloads; an invalid slot must read zero.
  task automatic check_slots(input int row, input logic [1:0] v,
                             input logic [31:0] p0, input logic [31:0] p1);
    string t;
    t = $sformatf("row%0d", row);
    check({t, " pc0"},     out_pc_0,          v[0] ? p0 : 32'h0);
    check({t, " pc1"},     out_pc_1,          v[1] ? p1 : 32'h0);
    check({t, " inst0"},   out_inst_0,        v[0] ? inst_of(p0) : 32'h0);
    check({t, " inst1"},   out_inst_1,        v[1] ? inst_of(p1) : 32'h0);
    check({t, " taken0"},  out_pred_taken_0,  v[0] ? p0[2] : 1'b0);
    check({t, " taken1"},  out_pred_taken_1,  v[1] ? p1[2] : 1'b0);
    check({t, " target0"}, out_pred_target_0, v[0] ? target_of(p0) : 32'h0);
    check({t, " target1"}, out_pred_target_1, v[1] ? target_of(p1) : 32'h0);
    check({t, " hist0"},   out_pred_hist_0,   v[0] ? hist_of(p0) : 8'h0);
    check({t, " hist1"},   out_pred_hist_1,   v[1] ? hist_of(p1) : 8'h0);
  endtask

  typedef struct {
    logic        stall;
    logic [1:0]  ev;
    logic [31:0] pc0, pc1;
    logic [1:0]  exp_valid;
    logic [3:0]  exp_count;
    logic        exp_ready;
    logic [31:0] exp_pc0, exp_pc1;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [1:0] ev, input logic [31:0] p0,
                              input logic [31:0] p1, input logic [1:0] v, input logic [3:0] c,
                              input logic r, input logic [31:0] e0, input logic [31:0] e1);
    vec_t x;
    x.stall = s; x.ev = ev; x.pc0 = p0; x.pc1 = p1;
    x.exp_valid = v; x.exp_count = c; x.exp_ready = r; x.exp_pc0 = e0; x.exp_pc1 = e1;
    return x;
  endfunction

  vec_t vecs [20];

  initial begin
    // Each row: inputs for one cycle, outputs expected before that cycle's clock edge.
    // Starts from head=tail=0 after a flush.
    vecs[0]  = mk(1, 2'b11, 32'h00, 32'h04, 2'b00, 0, 1, 32'h00, 32'h00);
    vecs[1]  = mk(1, 2'b11, 32'h08, 32'h0C, 2'b11, 2, 1, 32'h00, 32'h04);
    vecs[2]  = mk(1, 2'b11, 32'h10, 32'h14, 2'b11, 4, 1, 32'h00, 32'h04);
    vecs[3]  = mk(1, 2'b11, 32'h18, 32'h1C, 2'b11, 6, 1, 32'h00, 32'h04);
    vecs[4]  = mk(1, 2'b11, 32'h20, 32'h24, 2'b11, 8, 0, 32'h00, 32'h04);
    vecs[5]  = mk(0, 2'b11, 32'h20, 32'h24, 2'b11, 8, 0, 32'h00, 32'h04);
    vecs[6]  = mk(0, 2'b11, 32'h20, 32'h24, 2'b11, 6, 1, 32'h08, 32'h0C);
    vecs[7]  = mk(0, 2'b00, 32'h00, 32'h00, 2'b11, 6, 1, 32'h10, 32'h14);
    vecs[8]  = mk(0, 2'b00, 32'h00, 32'h00, 2'b11, 4, 1, 32'h18, 32'h1C);
    vecs[9]  = mk(0, 2'b00, 32'h00, 32'h00, 2'b11, 2, 1, 32'h20, 32'h24);
    vecs[10] = mk(1, 2'b11, 32'h40, 32'h44, 2'b00, 0, 1, 32'h00, 32'h00);
    vecs[11] = mk(1, 2'b11, 32'h48, 32'h4C, 2'b11, 2, 1, 32'h40, 32'h44);
    vecs[12] = mk(1, 2'b01, 32'h50, 32'h00, 2'b11, 4, 1, 32'h40, 32'h44);
    vecs[13] = mk(0, 2'b00, 32'h00, 32'h00, 2'b11, 5, 1, 32'h40, 32'h44);
    vecs[14] = mk(0, 2'b00, 32'h00, 32'h00, 2'b11, 3, 1, 32'h48, 32'h4C);
    vecs[15] = mk(0, 2'b01, 32'h58, 32'h00, 2'b01, 1, 1, 32'h50, 32'h00);
    vecs[16] = mk(1, 2'b11, 32'h60, 32'h64, 2'b01, 1, 1, 32'h58, 32'h00);
    vecs[17] = mk(0, 2'b00, 32'h00, 32'h00, 2'b11, 3, 1, 32'h58, 32'h60);
    vecs[18] = mk(0, 2'b00, 32'h00, 32'h00, 2'b01, 1, 1, 32'h64, 32'h00);
    vecs[19] = mk(0, 2'b00, 32'h00, 32'h00, 2'b00, 0, 1, 32'h00, 32'h00);

    drive(1, 0, 0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    // Reset mid-stream with a bundle offered: queue empties, bundle dropped.
    @(negedge clk); drive(0, 0, 1, 2'b11, 32'h40, 32'h44);
    @(negedge clk); drive(1, 0, 1, 2'b11, 32'h48, 32'h4C);
    #1 check("pre_reset count", count, 2);
    @(negedge clk); drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    #1;
    check("reset count", count, 0);
    check("reset valid", out_inst_valid, 2'b00);
    check("reset pc0", out_pc_0, 32'h0);
    check("reset inst0", out_inst_0, 32'h0);
    check("reset ready", enq_ready, 1'b1);

    // Basic flow: one pair in, out next cycle, gone the cycle after.
    @(negedge clk); drive(0, 0, 0, 2'b11, 32'h0, 32'h4);
    enq_inst_0 = 32'h00500093; enq_inst_1 = 32'h00a00113;
    @(negedge clk); drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    #1;
    check("flow valid", out_inst_valid, 2'b11);
    check("flow count", count, 2);
    check("flow pc0", out_pc_0, 32'h0);
    check("flow pc1", out_pc_1, 32'h4);
    check("flow inst0", out_inst_0, 32'h00500093);
    check("flow inst1", out_inst_1, 32'h00a00113);
    check("flow target1", out_pred_target_1, 32'h104);

    // Compaction: only slot 1 valid in the incoming bundle.
    @(negedge clk); drive(0, 0, 0, 2'b10, 32'hDEAD0000, 32'h8);
    enq_inst_1 = 32'h00c00193; enq_pred_taken_1 = 1'b1;
    enq_pred_target_1 = 32'h100; enq_pred_hist_1 = 8'h5A;
    #1;
    check("drained valid", out_inst_valid, 2'b00);
    check("drained count", count, 0);
    @(negedge clk); drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    #1;
    check("compact valid", out_inst_valid, 2'b01);
    check("compact count", count, 1);
    check("compact pc0", out_pc_0, 32'h8);
    check("compact inst0", out_inst_0, 32'h00c00193);
    check("compact taken0", out_pred_taken_0, 1'b1);
    check("compact target0", out_pred_target_0, 32'h100);
    check("compact hist0", out_pred_hist_0, 8'h5A);
    check("compact pc1", out_pc_1, 32'h0);
    check("compact inst1", out_inst_1, 32'h0);
    check("compact target1", out_pred_target_1, 32'h0);
    check("compact hist1", out_pred_hist_1, 8'h0);

    // Flush back to head=0 so the table starts from a known pointer position.
    @(negedge clk); drive(0, 1, 0, 2'b00, 32'h0, 32'h0);
    #1 check("pre_table flush valid", out_inst_valid, 2'b00);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(0, 0, vecs[i].stall, vecs[i].ev, vecs[i].pc0, vecs[i].pc1);
      #1;
      check($sformatf("row%0d valid", i), out_inst_valid, vecs[i].exp_valid);
      check($sformatf("row%0d count", i), count, vecs[i].exp_count);
      check($sformatf("row%0d ready", i), enq_ready, vecs[i].exp_ready);
      check_slots(i, vecs[i].exp_valid, vecs[i].exp_pc0, vecs[i].exp_pc1);
    end

    // Flush collides with an incoming bundle while five entries are queued.
    @(negedge clk); drive(0, 0, 1, 2'b11, 32'h70, 32'h74);
    @(negedge clk); drive(0, 0, 1, 2'b11, 32'h78, 32'h7C);
    @(negedge clk); drive(0, 0, 1, 2'b01, 32'h80, 32'h00);
    @(negedge clk); drive(0, 1, 0, 2'b11, 32'h90, 32'h94);
    #1;
    check("flush cycle count", count, 5);
    check("flush cycle valid", out_inst_valid, 2'b00);
    check("flush cycle pc0", out_pc_0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    #1;
    check("post_flush count", count, 0);
    check("post_flush valid", out_inst_valid, 2'b00);
    check("post_flush ready", enq_ready, 1'b1);
    @(negedge clk); drive(0, 0, 0, 2'b11, 32'hA0, 32'hA4);
    @(negedge clk); drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    #1;
    check("refill valid", out_inst_valid, 2'b11);
    check("refill count", count, 2);
    check("refill pc0", out_pc_0, 32'hA0);
    check("refill pc1", out_pc_1, 32'hA4);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
